// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction memory handshake, ID-facing buffer and
// the stall/redirect/halt controls coming back from ID/EX.
interface fetch_sequencer_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_mem_req;
  logic [WORD_SIZE-1:0] i_mem_addr;
  logic                 i_mem_ack;
  logic [WORD_SIZE-1:0] i_mem_data;
  logic                 if_valid;
  logic [WORD_SIZE-1:0] if_instr;
  logic [WORD_SIZE-1:0] if_pc;
  logic                 id_stall;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 halt;
  logic                 halted;
  logic [WORD_SIZE-1:0] pc_cur;

  modport master (
    output i_mem_req, i_mem_addr, if_valid, if_instr, if_pc, halted, pc_cur,
    input  i_mem_ack, i_mem_data, id_stall, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  i_mem_req, i_mem_addr, if_valid, if_instr, if_pc, halted, pc_cur,
    output i_mem_ack, i_mem_data, id_stall, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetcher with a
// one-entry buffer towards ID; handles redirects (squashing in-flight data) and HLT.
module fetch_sequencer #(
  parameter int WORD_SIZE = 16
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] ifpc_q, ifpc_d;
  logic                 squash_q, squash_d;
  logic                 halt_pend_q, halt_pend_d;
  logic                 consume;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    ifpc_d      = ifpc_q;
    squash_d    = squash_q;
    halt_pend_d = halt_pend_q;
    consume     = valid_q & ~bus.id_stall;

    if (consume) valid_d = 1'b0;

    case (state_q)
      S_RUN: begin
        if (!bus.redirect_valid) begin
          if (halt_pend_q) begin
            state_d = S_HALT;
          end else if (!valid_q || consume) begin
            state_d = S_WAIT;
            addr_d  = pc_q;
          end
        end
      end
      S_WAIT: begin
        if (bus.i_mem_ack) begin
          squash_d = 1'b0;
          state_d  = S_RUN;
          // Buffer is guaranteed empty here, so capture never overwrites a live word.
          if (!squash_q && !bus.redirect_valid && !halt_pend_q) begin
            instr_d = bus.i_mem_data;
            ifpc_d  = addr_q;
            valid_d = 1'b1;
            pc_d    = addr_q + WORD_SIZE'(1);
          end
          if (halt_pend_q && !bus.redirect_valid) state_d = S_HALT;
        end
      end
      default: ;
    endcase

    // Redirect outranks halt and normal fetch; the target replaces any PC update above.
    if (state_q != S_HALT) begin
      if (bus.redirect_valid) begin
        pc_d        = bus.redirect_pc;
        valid_d     = 1'b0;
        halt_pend_d = 1'b0;
        if (state_q == S_WAIT && !bus.i_mem_ack) squash_d = 1'b1;
      end else if (bus.halt) begin
        halt_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      pc_q        <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      ifpc_q      <= '0;
      squash_q    <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      ifpc_q      <= ifpc_d;
      squash_q    <= squash_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign bus.i_mem_req  = (state_q == S_WAIT);
  assign bus.i_mem_addr = addr_q;
  assign bus.if_valid   = valid_q;
  assign bus.if_instr   = instr_q;
  assign bus.if_pc      = ifpc_q;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.pc_cur     = pc_q;
endmodule
